// File: rtl/reg_scoreboard.sv
// Register scoreboard and write-port controller for a 16-entry register file.
// Optional same-cycle writeback bypass is enabled by defining REG_SCOREBOARD_BYPASS_EN.
module reg_scoreboard #(
   parameter int NREGS = 16,
   parameter int CNT_W = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     issueValidIn,
   input  logic [$clog2(NREGS)-1:0] sourceReg1In,
   input  logic [$clog2(NREGS)-1:0] sourceReg2In,
   input  logic                     sourceReg1ValidIn,
   input  logic                     sourceReg2ValidIn,
   input  logic [$clog2(NREGS)-1:0] destRegIn,
   input  logic                     destRegValidIn,
   input  logic [$clog2(NREGS)-1:0] destRegSpecialIn,
   input  logic                     destRegSpecialValidIn,
   output logic                     issueAcceptOut,
   output logic                     issueStallOut,
   output logic [63:0]              src1DataOut,
   output logic [63:0]              src2DataOut,
   input  logic                     wbValidIn,
   input  logic [$clog2(NREGS)-1:0] wbDestRegIn,
   input  logic [$clog2(NREGS)-1:0] wbDestRegSpecialIn,
   input  logic                     wbDestRegValidIn,
   input  logic                     wbDestRegSpecialValidIn,
   input  logic [63:0]              aluResultIn,
   input  logic [63:0]              aluResultSpecialIn,
   input  logic                     flushIn,
   output logic                     flushDoneOut,
   output logic                     regInUseBitMapOut [NREGS],
   output logic [63:0]              regFileOut [NREGS],
   output logic                     drainStateOut
);
   localparam int IDX_W = $clog2(NREGS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {RUN, DRAIN} state_e;

   state_e           state_q;
   logic             flush_done_q;
   logic [5:0]       total_q, total_d;
   logic [CNT_W-1:0] cnt_q [NREGS];
   logic [CNT_W-1:0] cnt_d [NREGS];
   logic [63:0]      rf_q [NREGS];
   logic [63:0]      rf_d [NREGS];
   logic [NREGS-1:0] inc, dec;
   logic [5:0]       n_inc, n_dec;
   logic             busy1, busy2, sat, hazard, accept;

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         // Decrement is floored at zero: a writeback with nothing pending only writes data.
         dec[i] = wbValidIn && (cnt_q[i] != '0) &&
                  ((wbDestRegValidIn && wbDestRegIn == IDX_W'(i)) ||
                   (wbDestRegSpecialValidIn && wbDestRegSpecialIn == IDX_W'(i)));
      end
`ifdef REG_SCOREBOARD_BYPASS_EN
      busy1 = (cnt_q[sourceReg1In] - CNT_W'(dec[sourceReg1In])) != '0;
      busy2 = (cnt_q[sourceReg2In] - CNT_W'(dec[sourceReg2In])) != '0;
`else
      busy1 = cnt_q[sourceReg1In] != '0;
      busy2 = cnt_q[sourceReg2In] != '0;
`endif
      sat    = (destRegValidIn && cnt_q[destRegIn] == CNT_MAX) ||
               (destRegSpecialValidIn && cnt_q[destRegSpecialIn] == CNT_MAX);
      hazard = (sourceReg1ValidIn && busy1) || (sourceReg2ValidIn && busy2) || sat;
      accept = issueValidIn && state_q == RUN && !flushIn && !hazard;

      n_inc = '0;
      n_dec = '0;
      for (int i = 0; i < NREGS; i++) begin
         inc[i] = accept &&
                  ((destRegValidIn && destRegIn == IDX_W'(i)) ||
                   (destRegSpecialValidIn && destRegSpecialIn == IDX_W'(i)));
         cnt_d[i] = cnt_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
         n_inc    = n_inc + 6'(inc[i]);
         n_dec    = n_dec + 6'(dec[i]);
         rf_d[i]  = rf_q[i];
         if (wbValidIn && wbDestRegSpecialValidIn && wbDestRegSpecialIn == IDX_W'(i))
            rf_d[i] = aluResultSpecialIn;
         if (wbValidIn && wbDestRegValidIn && wbDestRegIn == IDX_W'(i))
            rf_d[i] = aluResultIn;
      end
      total_d = total_q + n_inc - n_dec;
   end

   always_comb begin
      src1DataOut = rf_q[sourceReg1In];
      src2DataOut = rf_q[sourceReg2In];
`ifdef REG_SCOREBOARD_BYPASS_EN
      if (wbValidIn && wbDestRegValidIn && wbDestRegIn == sourceReg1In)
         src1DataOut = aluResultIn;
      else if (wbValidIn && wbDestRegSpecialValidIn && wbDestRegSpecialIn == sourceReg1In)
         src1DataOut = aluResultSpecialIn;
      if (wbValidIn && wbDestRegValidIn && wbDestRegIn == sourceReg2In)
         src2DataOut = aluResultIn;
      else if (wbValidIn && wbDestRegSpecialValidIn && wbDestRegSpecialIn == sourceReg2In)
         src2DataOut = aluResultSpecialIn;
`endif
      for (int i = 0; i < NREGS; i++) begin
         regInUseBitMapOut[i] = cnt_q[i] != '0;
         regFileOut[i]        = rf_q[i];
      end
   end

   assign issueAcceptOut = accept;
   assign issueStallOut  = issueValidIn && !accept;
   assign flushDoneOut   = flush_done_q;
   assign drainStateOut  = state_q == DRAIN;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            cnt_q[i] <= '0;
            rf_q[i]  <= '0;
         end
         total_q      <= '0;
         state_q      <= RUN;
         flush_done_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            cnt_q[i] <= cnt_d[i];
            rf_q[i]  <= rf_d[i];
         end
         total_q      <= total_d;
         flush_done_q <= 1'b0;
         case (state_q)
            RUN:   if (flushIn) state_q <= DRAIN;
            DRAIN: if (total_d == '0) begin
               state_q      <= RUN;
               flush_done_q <= 1'b1;
            end
            default: state_q <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: driver pushes expected issue decisions and
// flush-done cycles into queues, a negedge monitor pops and compares them.
module tb_reg_scoreboard;
   logic        clk = 1'b0;
   logic        reset;
   logic        issueValidIn, sourceReg1ValidIn, sourceReg2ValidIn;
   logic [3:0]  sourceReg1In, sourceReg2In, destRegIn, destRegSpecialIn;
   logic        destRegValidIn, destRegSpecialValidIn;
   logic        issueAcceptOut, issueStallOut;
   logic [63:0] src1DataOut, src2DataOut;
   logic        wbValidIn, wbDestRegValidIn, wbDestRegSpecialValidIn;
   logic [3:0]  wbDestRegIn, wbDestRegSpecialIn;
   logic [63:0] aluResultIn, aluResultSpecialIn;
   logic        flushIn, flushDoneOut, drainStateOut;
   logic        in_use [16];
   logic [63:0] rf_o [16];

   logic [1:0]  exp_q[$];
   int          fd_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   reg_scoreboard dut (
      .clk(clk), .reset(reset),
      .issueValidIn(issueValidIn),
      .sourceReg1In(sourceReg1In), .sourceReg2In(sourceReg2In),
      .sourceReg1ValidIn(sourceReg1ValidIn), .sourceReg2ValidIn(sourceReg2ValidIn),
      .destRegIn(destRegIn), .destRegValidIn(destRegValidIn),
      .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
      .issueAcceptOut(issueAcceptOut), .issueStallOut(issueStallOut),
      .src1DataOut(src1DataOut), .src2DataOut(src2DataOut),
      .wbValidIn(wbValidIn), .wbDestRegIn(wbDestRegIn), .wbDestRegSpecialIn(wbDestRegSpecialIn),
      .wbDestRegValidIn(wbDestRegValidIn), .wbDestRegSpecialValidIn(wbDestRegSpecialValidIn),
      .aluResultIn(aluResultIn), .aluResultSpecialIn(aluResultSpecialIn),
      .flushIn(flushIn), .flushDoneOut(flushDoneOut),
      .regInUseBitMapOut(in_use), .regFileOut(rf_o),
      .drainStateOut(drainStateOut)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Monitor: compares every presented issue decision and every flush-done pulse
   always @(negedge clk) begin
      if (!reset) begin
         if (issueValidIn) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL issue_resp: decision acc=%0b at cycle %0d with no expected entry",
                        issueAcceptOut, cyc);
            end else begin
               logic [1:0] e;
               e = exp_q.pop_front();
               if ({issueAcceptOut, issueStallOut} !== e) begin
                  n_fail++;
                  $display("FAIL issue_resp: cycle %0d got acc/stall=%b expected %b",
                           cyc, {issueAcceptOut, issueStallOut}, e);
               end
            end
         end
         if (flushDoneOut) begin
            n_checks++;
            if (fd_q.size() == 0) begin
               n_fail++;
               $display("FAIL flush_done: unexpected pulse at cycle %0d", cyc);
            end else begin
               int e;
               e = fd_q.pop_front();
               if (cyc != e) begin
                  n_fail++;
                  $display("FAIL flush_done: pulse at cycle %0d expected cycle %0d", cyc, e);
               end
            end
         end
      end
   end

   // Driver tasks
   task automatic clear_inputs();
      issueValidIn = 0; sourceReg1ValidIn = 0; sourceReg2ValidIn = 0;
      sourceReg1In = 0; sourceReg2In = 0; destRegIn = 0; destRegSpecialIn = 0;
      destRegValidIn = 0; destRegSpecialValidIn = 0;
      wbValidIn = 0; wbDestRegValidIn = 0; wbDestRegSpecialValidIn = 0;
      wbDestRegIn = 0; wbDestRegSpecialIn = 0; aluResultIn = 0; aluResultSpecialIn = 0;
      flushIn = 0;
   endtask

   task automatic issue(input logic s1v, input logic [3:0] s1, input logic s2v, input logic [3:0] s2,
                        input logic dv, input logic [3:0] d, input logic dsv, input logic [3:0] ds,
                        input logic acc);
      issueValidIn = 1;
      sourceReg1ValidIn = s1v; sourceReg1In = s1;
      sourceReg2ValidIn = s2v; sourceReg2In = s2;
      destRegValidIn = dv; destRegIn = d;
      destRegSpecialValidIn = dsv; destRegSpecialIn = ds;
      exp_q.push_back({acc, ~acc});
   endtask

   task automatic issue_dest(input logic [3:0] d, input logic acc);
      issue(0, 0, 0, 0, 1, d, 0, 0, acc);
   endtask

   task automatic wb(input logic dv, input logic [3:0] d, input logic dsv, input logic [3:0] ds,
                     input logic [63:0] a, input logic [63:0] as);
      wbValidIn = 1;
      wbDestRegValidIn = dv; wbDestRegIn = d;
      wbDestRegSpecialValidIn = dsv; wbDestRegSpecialIn = ds;
      aluResultIn = a; aluResultSpecialIn = as;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic check_all_clear(input string tag);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("%s_rf%0d", tag, i), rf_o[i], 64'h0);
         check($sformatf("%s_inuse%0d", tag, i), 64'(in_use[i]), 64'h0);
      end
      check({tag, "_flushdone"}, 64'(flushDoneOut), 64'h0);
      check({tag, "_drain"}, 64'(drainStateOut), 64'h0);
   endtask

   initial begin
      // Clock/reset block
      reset = 1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      #1;
      check_all_clear("reset");
      check("reset_accept", 64'(issueAcceptOut), 64'h0);
      check("reset_stall", 64'(issueStallOut), 64'h0);

      // RAW hazard on R3
      issue_dest(4'd3, 1); step();
      check("r3_inuse", 64'(in_use[3]), 64'h1);
      issue(1, 4'd3, 0, 0, 0, 0, 0, 0, 0); step();
`ifdef REG_SCOREBOARD_BYPASS_EN
      issue(1, 4'd3, 0, 0, 0, 0, 0, 0, 1);
      wb(1, 4'd3, 0, 0, 64'hDEAD, 64'h0);
      #1;
      check("r3_bypass_data", src1DataOut, 64'hDEAD);
`else
      issue(1, 4'd3, 0, 0, 0, 0, 0, 0, 0);
      wb(1, 4'd3, 0, 0, 64'hDEAD, 64'h0);
`endif
      step();
      issue(1, 4'd3, 1, 4'd3, 0, 0, 0, 0, 1);
      #1;
      check("r3_src1", src1DataOut, 64'hDEAD);
      check("r3_src2", src2DataOut, 64'hDEAD);
      check("r3_rf", rf_o[3], 64'hDEAD);
      check("r3_inuse_clr", 64'(in_use[3]), 64'h0);
      step();

      // Counter saturation on R5
      repeat (3) begin issue_dest(4'd5, 1); step(); end
      check("r5_inuse", 64'(in_use[5]), 64'h1);
      issue_dest(4'd5, 0); step();
      issue_dest(4'd5, 0); wb(1, 4'd5, 0, 0, 64'h55, 64'h0); step();
      issue_dest(4'd5, 1); step();
      repeat (3) begin wb(1, 4'd5, 0, 0, 64'h5A, 64'h0); step(); end
      check("r5_inuse_clr", 64'(in_use[5]), 64'h0);
      check("r5_rf", rf_o[5], 64'h5A);

      // Dual destination, distinct and identical
      issue(0, 0, 0, 0, 1, 4'd1, 1, 4'd2, 1); step();
      wb(1, 4'd1, 1, 4'd2, 64'h11, 64'h22); step();
      check("r1_rf", rf_o[1], 64'h11);
      check("r2_rf", rf_o[2], 64'h22);
      check("r1_inuse", 64'(in_use[1]), 64'h0);
      check("r2_inuse", 64'(in_use[2]), 64'h0);
      issue(0, 0, 0, 0, 1, 4'd4, 1, 4'd4, 1); step();
      wb(1, 4'd4, 1, 4'd4, 64'hAAAA, 64'hBBBB); step();
      check("r4_rf_primary", rf_o[4], 64'hAAAA);
      check("r4_inuse", 64'(in_use[4]), 64'h0);

      // Same-cycle issue and writeback on R7
      issue_dest(4'd7, 1); step();
      issue_dest(4'd7, 1); wb(1, 4'd7, 0, 0, 64'h77, 64'h0); step();
      check("r7_inuse_net", 64'(in_use[7]), 64'h1);
      check("r7_rf", rf_o[7], 64'h77);
      wb(1, 4'd7, 0, 0, 64'h78, 64'h0); step();
      check("r7_inuse_clr", 64'(in_use[7]), 64'h0);

      // Flush drain with two outstanding writes
      issue_dest(4'd8, 1); step();
      issue_dest(4'd9, 1); step();
      flushIn = 1; issue_dest(4'd10, 0); step();
      check("drain_entered", 64'(drainStateOut), 64'h1);
      issue_dest(4'd10, 0); flushIn = 1; wb(1, 4'd8, 0, 0, 64'h88, 64'h0); step();
      issue_dest(4'd10, 0); wb(1, 4'd9, 0, 0, 64'h99, 64'h0); fd_q.push_back(cyc + 1); step();
      issue_dest(4'd10, 1); step();
      wb(1, 4'd10, 0, 0, 64'hA0, 64'h0); step();

      // Flush with nothing outstanding exits after one drain cycle
      flushIn = 1; fd_q.push_back(cyc + 2); step();
      issue_dest(4'd0, 0); step();
      step();

      // Reset while draining with pending writes
      issue_dest(4'd11, 1); step();
      issue_dest(4'd12, 1); step();
      flushIn = 1; step();
      check("pre_reset_drain", 64'(drainStateOut), 64'h1);
      reset = 1;
      #1;
      check_all_clear("midreset");
      @(posedge clk);
      #1;
      reset = 0;
      issue_dest(4'd13, 1); step();
      wb(1, 4'd11, 0, 0, 64'h99, 64'h0); step();
      check("stale_wb_rf", rf_o[11], 64'h99);
      check("stale_wb_inuse", 64'(in_use[11]), 64'h0);
      wb(1, 4'd13, 0, 0, 64'h13, 64'h0); step();
      flushIn = 1; fd_q.push_back(cyc + 2); step();
      repeat (3) step();

      // Final report
      check("exp_q_empty", 64'(exp_q.size()), 64'h0);
      check("fd_q_empty", 64'(fd_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
